// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - if_id_reg     : IF/ID pipeline register layout (same layout as the
//                     pipeline-buffer package: Curr_Pc in the upper bits,
//                     Curr_Instr in the lower 32 bits)
//   - fetch_state_e : fetch controller states
//   - NOP_INSTR     : bubble instruction (addi x0,x0,0)
//   - PC_STEP       : byte increment between sequential fetches
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  localparam int          IF_PC_W   = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef struct packed {
    logic [IF_PC_W-1:0] Curr_Pc;
    logic [31:0]        Curr_Instr;
  } if_id_reg;

  typedef enum logic [2:0] {
    FETCH,   // request outstanding on the port
    WAIT,    // granted, waiting for the response
    HOLD,    // response parked in the skid buffer behind a stall
    DRAIN,   // halt seen with a fetch in flight; swallow its response
    HALTED   // fetch stopped for good
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry buffer that parks a returned instruction while decode is
//   stalled and IF/ID is already occupied.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : capture data_in, mark full
//     unload     : entry consumed, mark empty
//     clear      : drop the entry (flush/halt); wins over load
//     data_in    : entry to park
//     data       : parked entry (meaningful only while full=1)
//     full       : entry valid
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     unload,
  input  logic     clear,
  input  if_id_reg data_in,
  output if_id_reg data,
  output logic     full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is deliberately left out of reset; 'full' qualifies
  // every read, so resetting the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= data_in;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage: owns the PC, issues one fetch at a time over a
//   request/grant/response port, and fills the IF/ID register for decode.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     stall_i             : hold IF/ID, do not hand over new instructions
//     flush_i             : squash IF/ID, skid entry and the in-flight fetch
//     redirect_i          : load redirect_pc_i into the PC, kill in-flight fetch
//     redirect_pc_i       : redirect target
//     halt_i              : stop fetching permanently
//     imem_req_o          : fetch request (address = pc)
//     imem_addr_o         : fetch address
//     imem_gnt_i          : request accepted this cycle
//     imem_rvalid_i       : response valid (at least one cycle after grant)
//     imem_rdata_i        : instruction word
//     if_id_o             : IF/ID register {Curr_Pc, Curr_Instr}
//     if_id_valid_o       : if_id_o holds a real instruction
//     halted_o            : fetch stopped and drained
// -----------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::IF_PC_W;
  import if_fetch_stage_pkg::PC_STEP;
  import if_fetch_stage_pkg::if_id_reg;
  import if_fetch_stage_pkg::fetch_state_e;
  import if_fetch_stage_pkg::FETCH;
  import if_fetch_stage_pkg::WAIT;
  import if_fetch_stage_pkg::HOLD;
  import if_fetch_stage_pkg::DRAIN;
  import if_fetch_stage_pkg::HALTED;
#(
  parameter int unsigned       PC_W      = IF_PC_W,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output if_id_reg        if_id_o,
  output logic            if_id_valid_o,
  output logic            halted_o
);

  localparam if_id_reg BUBBLE = '{Curr_Pc: '0, Curr_Instr: NOP_INSTR};

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inflight_q, pc_inflight_d;
  logic            kill_q, kill_d;
  if_id_reg        if_id_q, if_id_d;
  logic            valid_q, valid_d;

  logic            gnt;
  logic            drop_rsp;
  logic            out_free;
  if_id_reg        rsp_entry;
  logic            skid_load, skid_unload, skid_clear, skid_full;
  if_id_reg        skid_data;

  // Request is masked by rst_n so nothing is asked for while reset is held.
  assign imem_req_o  = (state_q == FETCH) && rst_n;
  assign imem_addr_o = pc_q;
  assign gnt         = imem_req_o && imem_gnt_i;

  // A response is dropped if its fetch was already killed, or if a flush or
  // redirect arrives in the very cycle it returns.
  assign drop_rsp  = kill_q || flush_i || redirect_i;
  assign out_free  = !stall_i || !valid_q;
  assign rsp_entry = '{Curr_Pc: pc_inflight_q, Curr_Instr: imem_rdata_i};

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .data_in (rsp_entry),
    .data    (skid_data),
    .full    (skid_full)
  );

  // NOTE: every signal driven here gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight_q;
    kill_d        = kill_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_clear    = 1'b0;
    // With no new instruction, IF/ID holds under stall and bubbles otherwise.
    if_id_d       = stall_i ? if_id_q : BUBBLE;
    valid_d       = stall_i && valid_q;

    if (halt_i) begin
      // Halt outranks redirect, flush and grant.
      kill_d     = 1'b0;
      skid_clear = 1'b1;
      if_id_d    = BUBBLE;
      valid_d    = 1'b0;
      case (state_q)
        FETCH:       state_d = gnt ? DRAIN : HALTED;
        WAIT, DRAIN: state_d = imem_rvalid_i ? HALTED : DRAIN;
        default:     state_d = HALTED;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (gnt) begin
            state_d       = WAIT;
            pc_inflight_d = pc_q;
            pc_d          = pc_q + PC_W'(PC_STEP);
            kill_d        = flush_i || redirect_i;
          end
          if (redirect_i) pc_d = redirect_pc_i;
        end
        WAIT: begin
          if (redirect_i) pc_d = redirect_pc_i;
          if (imem_rvalid_i) begin
            kill_d  = 1'b0;
            state_d = FETCH;
            if (!drop_rsp) begin
              if (out_free) begin
                if_id_d = rsp_entry;
                valid_d = 1'b1;
              end else begin
                skid_load = 1'b1;
                state_d   = HOLD;
              end
            end
          end else begin
            kill_d = drop_rsp;
          end
        end
        HOLD: begin
          if (redirect_i) pc_d = redirect_pc_i;
          if (flush_i) begin
            state_d = FETCH;
          end else if (!stall_i) begin
            skid_unload = 1'b1;
            if_id_d     = skid_data;
            valid_d     = skid_full;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          if (imem_rvalid_i) state_d = HALTED;
        end
        default: begin
        end
      endcase

      // Flush beats stall and any data arriving this cycle.
      if (flush_i) begin
        if_id_d    = BUBBLE;
        valid_d    = 1'b0;
        skid_clear = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pc_inflight_q <= RESET_PC;
      kill_q        <= 1'b0;
      if_id_q       <= BUBBLE;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_inflight_q <= pc_inflight_d;
      kill_q        <= kill_d;
      if_id_q       <= if_id_d;
      valid_q       <= valid_d;
    end
  end

  assign if_id_o       = if_id_q;
  assign if_id_valid_o = valid_q;
  assign halted_o      = (state_q == HALTED);

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Self-checking bench for if_fetch_stage. A behavioural instruction memory
//   grants a limited number of requests and answers after mem_lat cycles;
//   expected IF/ID entries are queued by the stimulus and compared when the
//   stage presents a new instruction.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_i, halt_i;
  logic [8:0]  redirect_pc_i;
  logic        imem_req_o;
  logic [8:0]  imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  if_id_reg    if_id_o;
  logic        if_id_valid_o, halted_o;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_o       (if_id_o),
    .if_id_valid_o (if_id_valid_o),
    .halted_o      (halted_o)
  );

  int         checks   = 0;
  int         failures = 0;
  if_id_reg   exp_q[$];
  if_id_reg   last_exp;
  if_id_reg   bubble_item;
  logic       got;
  logic       prev_valid;
  int         cyc;
  int         grants_left;
  int         mem_lat;
  int         lat_cnt;
  logic       pend;
  logic [8:0] pend_addr;

  typedef struct {
    logic [8:0] target;
    logic       flush;
    logic       at_gnt;  // 1: redirect coincides with the grant, 0: during WAIT
    logic [8:0] exp0;
    logic [8:0] exp1;
  } redir_vec_t;

  redir_vec_t vecs[4];

  function automatic logic [31:0] word(input logic [8:0] a);
    return 32'hA500_0000 ^ {7'h0, a, 7'h0, a};
  endfunction

  function automatic if_id_reg item(input logic [8:0] a);
    return '{Curr_Pc: a, Curr_Instr: word(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, score any new IF/ID entry,
  // then drive the memory response/grant for the next rising edge.
  task automatic step();
    logic stall_now;
    stall_now = stall_i;
    @(negedge clk);
    cyc++;
    got = 1'b0;
    if (if_id_valid_o && !(prev_valid && stall_now)) begin
      got = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: actual pc=%0h instr=%0h, required none",
                 if_id_o.Curr_Pc, if_id_o.Curr_Instr);
      end else begin
        last_exp = exp_q.pop_front();
        check($sformatf("if_id_pc%0h", last_exp.Curr_Pc), if_id_o, last_exp);
      end
    end
    prev_valid = if_id_valid_o;

    imem_rvalid_i = 1'b0;
    if (pend) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word(pend_addr);
        pend          = 1'b0;
      end
    end
    imem_gnt_i = 1'b0;
    if (imem_req_o && grants_left > 0 && !pend) begin
      imem_gnt_i = 1'b1;
      grants_left--;
      pend      = 1'b1;
      lat_cnt   = mem_lat;
      pend_addr = imem_addr_o;
    end
  endtask

  task automatic run_until_got(input string name, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!got && n < budget);
    check(name, got, 1'b1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int t[3];
    int n;
    int req_seen;

    vecs[0] = '{target: 9'h100, flush: 1'b1, at_gnt: 1'b0, exp0: 9'h100, exp1: 9'h104};
    vecs[1] = '{target: 9'h1FC, flush: 1'b0, at_gnt: 1'b0, exp0: 9'h1FC, exp1: 9'h000};
    vecs[2] = '{target: 9'h0F8, flush: 1'b1, at_gnt: 1'b1, exp0: 9'h0F8, exp1: 9'h0FC};
    vecs[3] = '{target: 9'h040, flush: 1'b0, at_gnt: 1'b1, exp0: 9'h040, exp1: 9'h044};

    bubble_item   = '{Curr_Pc: 9'h000, Curr_Instr: 32'h0000_0013};
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    halt_i        = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    grants_left   = 0;
    mem_lat       = 1;
    lat_cnt       = 0;
    pend          = 1'b0;
    pend_addr     = '0;
    prev_valid    = 1'b0;
    got           = 1'b0;
    cyc           = 0;
    rst_n         = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", imem_req_o, 1'b0);
    check("rst_valid", if_id_valid_o, 1'b0);
    check("rst_if_id", if_id_o, bubble_item);
    check("rst_halted", halted_o, 1'b0);
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle memory: PCs 0,4,8 with valid every 2 cycles
    grants_left = 3;
    mem_lat     = 1;
    exp_q.push_back(item(9'h000));
    exp_q.push_back(item(9'h004));
    exp_q.push_back(item(9'h008));
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      step();
      if (got) begin
        t[n] = cyc;
        n++;
      end
    end
    check("seq_count", n, 3);
    check("seq_gap01", t[1] - t[0], 2);
    check("seq_gap12", t[2] - t[1], 2);

    // Stall while a response returns: parked in skid, delivered after release
    grants_left = 2;
    exp_q.push_back(item(9'h00C));
    exp_q.push_back(item(9'h010));
    run_until_got("stall_first", 20);
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), if_id_o, item(9'h00C));
      check($sformatf("stall_valid%0d", i), if_id_valid_o, 1'b1);
    end
    check("stall_no_req", imem_req_o, 1'b0);
    stall_i = 1'b0;
    run_until_got("stall_skid_out", 10);
    grants_left = 1;
    exp_q.push_back(item(9'h014));
    drain("stall_next", 20);

    // Redirect table: in-flight fetch killed, fetch resumes at target
    for (int i = 0; i < 4; i++) begin
      mem_lat     = 3;
      grants_left = 1;
      step();
      if (!vecs[i].at_gnt) step();
      redirect_i    = 1'b1;
      redirect_pc_i = vecs[i].target;
      flush_i       = vecs[i].flush;
      step();
      redirect_i = 1'b0;
      flush_i    = 1'b0;
      repeat (5) step();
      check($sformatf("redir%0d_req", i), imem_req_o, 1'b1);
      check($sformatf("redir%0d_addr", i), imem_addr_o, vecs[i].exp0);
      mem_lat     = 1;
      grants_left = 2;
      exp_q.push_back(item(vecs[i].exp0));
      exp_q.push_back(item(vecs[i].exp1));
      drain($sformatf("redir%0d_drain", i), 20);
    end

    // Halt while WAIT: drain the response, then stay halted and silent
    mem_lat     = 3;
    grants_left = 1;
    step();
    step();
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    check("drain_halted", halted_o, 1'b0);
    check("drain_req", imem_req_o, 1'b0);
    step();
    step();
    check("halt_halted", halted_o, 1'b1);
    grants_left = 5;
    req_seen    = 0;
    for (int i = 0; i < 20; i++) begin
      redirect_i    = (i % 2 == 0);
      redirect_pc_i = 9'h080;
      step();
      if (imem_req_o) req_seen++;
    end
    redirect_i = 1'b0;
    check("halt_req_quiet", req_seen, 0);
    check("halt_sticky", halted_o, 1'b1);
    check("halt_valid", if_id_valid_o, 1'b0);

    // Reset mid-WAIT, stale response lands in FETCH and is ignored
    grants_left = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_lat     = 4;
    grants_left = 1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_req", imem_req_o, 1'b0);
    check("midrst_valid", if_id_valid_o, 1'b0);
    check("midrst_if_id", if_id_o, bubble_item);
    check("midrst_halted", halted_o, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("stale_valid", if_id_valid_o, 1'b0);
    check("stale_if_id", if_id_o, bubble_item);
    check("stale_req", imem_req_o, 1'b1);
    check("stale_addr", imem_addr_o, 9'h000);
    grants_left = 1;
    mem_lat     = 1;
    exp_q.push_back(item(9'h000));
    drain("restart_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
